// File: rtl/ps2_kbd_tx_if.sv
// Host-side byte queue port of the PS/2 keyboard transmitter.
// master = byte source, slave = transmitter.
interface ps2_kbd_tx_if;
    logic [7:0] data_in;
    logic       data_valid;
    logic       fifo_full;
    logic       overflow;
    logic       busy;

    modport master (
        output data_in,
        output data_valid,
        input  fifo_full,
        input  overflow,
        input  busy
    );

    modport slave (
        input  data_in,
        input  data_valid,
        output fifo_full,
        output overflow,
        output busy
    );
endinterface

// File: rtl/ps2_kbd_tx.sv
// PS/2 device-side transmitter: queues scancode bytes in a FIFO and sends each as an
// 11-bit frame (start, 8 data LSB first, odd parity, stop) on registered clk/data lines.
module ps2_kbd_tx #(
    parameter int unsigned CLK_DIV   = 750,
    parameter int unsigned FIFO_AW   = 4,
    parameter int unsigned GAP_TICKS = 4
) (
    input  logic        clk_sys,
    input  logic        reset,
    ps2_kbd_tx_if.slave host,
    output logic        ps2_kbd_clk,
    output logic        ps2_kbd_data
);
    localparam int unsigned Depth = 2 ** FIFO_AW;
    localparam int unsigned CntW  = FIFO_AW + 1;
    localparam int unsigned DivW  = $clog2(CLK_DIV);
    localparam int unsigned GapW  = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;

    typedef enum logic [1:0] {StIdle, StBitHi, StBitLo, StGap} state_e;

    logic [DivW-1:0]    div_q, div_d;
    logic               tick;
    logic [7:0]         mem_q [Depth];
    logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]    count_q, count_d;
    logic               ovf_q, ovf_d;
    logic               full, empty, push, pop;
    logic [7:0]         rd_byte;

    state_e             state_q, state_d;
    logic [10:0]        frame_q, frame_d;
    logic [3:0]         idx_q, idx_d;
    logic [GapW-1:0]    gap_q, gap_d;
    logic               clk_q, clk_d, data_q, data_d;

    assign tick    = (div_q == DivW'(CLK_DIV - 1));
    assign full    = (count_q == CntW'(Depth));
    assign empty   = (count_q == '0);
    assign push    = host.data_valid & ~full;
    assign rd_byte = mem_q[rd_ptr_q];

    // Prescaler and FIFO bookkeeping; an overflowing write is dropped even if a pop frees a slot.
    always_comb begin
        div_d    = tick ? '0 : div_q + 1'b1;
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        ovf_d    = ovf_q | (host.data_valid & full);
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        frame_d = frame_q;
        idx_d   = idx_q;
        gap_d   = gap_q;
        clk_d   = clk_q;
        data_d  = data_q;
        pop     = 1'b0;
        if (tick) begin
            unique case (state_q)
                StIdle: begin
                    clk_d  = 1'b1;
                    data_d = 1'b1;
                    if (!empty) begin
                        pop     = 1'b1;
                        frame_d = {1'b1, ~(^rd_byte), rd_byte, 1'b0};
                        idx_d   = '0;
                        data_d  = 1'b0;
                        state_d = StBitHi;
                    end
                end
                StBitHi: begin
                    clk_d   = 1'b0;
                    state_d = StBitLo;
                end
                StBitLo: begin
                    clk_d = 1'b1;
                    if (idx_q < 4'd10) begin
                        idx_d   = idx_q + 4'd1;
                        data_d  = frame_q[idx_d];
                        state_d = StBitHi;
                    end else begin
                        data_d  = 1'b1;
                        gap_d   = '0;
                        state_d = StGap;
                    end
                end
                StGap: begin
                    clk_d  = 1'b1;
                    data_d = 1'b1;
                    if (gap_q == GapW'(GAP_TICKS - 1)) begin
                        state_d = StIdle;
                    end else begin
                        gap_d = gap_q + 1'b1;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            div_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            state_q  <= StIdle;
            frame_q  <= '1;
            idx_q    <= '0;
            gap_q    <= '0;
            clk_q    <= 1'b1;
            data_q   <= 1'b1;
        end else begin
            div_q    <= div_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            state_q  <= state_d;
            frame_q  <= frame_d;
            idx_q    <= idx_d;
            gap_q    <= gap_d;
            clk_q    <= clk_d;
            data_q   <= data_d;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (push) begin
            mem_q[wr_ptr_q] <= host.data_in;
        end
    end

    assign host.fifo_full = full;
    assign host.overflow  = ovf_q;
    assign host.busy      = (state_q != StIdle) | ~empty;
    assign ps2_kbd_clk    = clk_q;
    assign ps2_kbd_data   = data_q;
endmodule

// File: tb/tb_ps2_kbd_tx.sv
// Bench for ps2_kbd_tx: a behavioural PS/2 receiver samples data on falling clock edges
// and its decoded bytes are compared against the queue of bytes the bench wrote.
module tb_ps2_kbd_tx;
    localparam int ClkDiv   = 4;
    localparam int GapTicks = 4;
    localparam int FifoAw   = 4;
    localparam int Depth    = 16;

    logic clk_sys = 1'b0;
    logic reset   = 1'b1;
    logic ps2_kbd_clk, ps2_kbd_data;

    ps2_kbd_tx_if host ();

    ps2_kbd_tx #(
        .CLK_DIV  (ClkDiv),
        .FIFO_AW  (FifoAw),
        .GAP_TICKS(GapTicks)
    ) dut (
        .clk_sys     (clk_sys),
        .reset       (reset),
        .host        (host),
        .ps2_kbd_clk (ps2_kbd_clk),
        .ps2_kbd_data(ps2_kbd_data)
    );

    always #5 clk_sys = ~clk_sys;

    int checks = 0;
    int errors = 0;

    // Receiver model state.
    int          cyc = 0, nbits = 0, fall_cnt = 0, frame_err = 0, dtrans_err = 0;
    int          lo_err = 0, lo_spans = 0, lo_len = 0, stop_seen = 0;
    int          stop_rise_cyc = 0, start_cyc = 0, gap_last = 0;
    bit          stop_pending = 1'b0;
    logic        prev_c = 1'b1, prev_d = 1'b1;
    logic [10:0] bits_cur = '0, last_bits = '0;
    logic [7:0]  rx_q[$];
    logic        par_q[$];
    logic [7:0]  exp_q[$];

    always @(posedge clk_sys) begin
        #1;
        cyc++;
        if (reset) begin
            nbits = 0; prev_c = 1'b1; prev_d = 1'b1; lo_len = 0; stop_pending = 1'b0;
        end else begin
            if (prev_c === 1'b1 && ps2_kbd_clk === 1'b0) begin
                bits_cur = {ps2_kbd_data, bits_cur[10:1]};
                nbits++;
                fall_cnt++;
                if (nbits == 11) begin
                    last_bits = bits_cur;
                    nbits = 0;
                    stop_pending = 1'b1;
                    if (bits_cur[0] !== 1'b0 || bits_cur[10] !== 1'b1 || (^bits_cur[9:1]) !== 1'b1)
                        frame_err++;
                    rx_q.push_back(bits_cur[8:1]);
                    par_q.push_back(bits_cur[9]);
                end
            end
            if (prev_c === 1'b0 && ps2_kbd_clk === 1'b0 && ps2_kbd_data !== prev_d) dtrans_err++;
            if (ps2_kbd_clk === 1'b0) lo_len++;
            if (prev_c === 1'b0 && ps2_kbd_clk === 1'b1) begin
                lo_spans++;
                if (lo_len != ClkDiv) lo_err++;
                lo_len = 0;
                if (stop_pending) begin
                    stop_pending = 1'b0;
                    stop_rise_cyc = cyc;
                    stop_seen++;
                end
            end
            if (prev_c === 1'b1 && ps2_kbd_clk === 1'b1 && prev_d === 1'b1 && ps2_kbd_data === 1'b0
                && nbits == 0) begin
                start_cyc = cyc;
                gap_last = cyc - stop_rise_cyc;
            end
            prev_c = ps2_kbd_clk;
            prev_d = ps2_kbd_data;
        end
    end

    function automatic logic [10:0] frame_of(input logic [7:0] b);
        return {1'b1, ~(^b), b, 1'b0};
    endfunction

    task automatic drive_byte(input logic [7:0] b);
        @(negedge clk_sys);
        host.data_in    = b;
        host.data_valid = 1'b1;
    endtask

    task automatic release_valid();
        @(negedge clk_sys);
        host.data_valid = 1'b0;
    endtask

    task automatic wait_rx(input int n, input int budget, output bit ok);
        int k = 0;
        while (rx_q.size() < n && k < budget) begin
            @(negedge clk_sys);
            k++;
        end
        ok = (rx_q.size() >= n);
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        int k = 0;
        while (host.busy !== 1'b0 && k < budget) begin
            @(negedge clk_sys);
            k++;
        end
        ok = (host.busy === 1'b0);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk_sys);
        reset = 1'b0;
        @(negedge clk_sys);
        checks++; if (ps2_kbd_clk !== 1'b1) begin errors++; $display("FAIL reset_clk got %b want 1", ps2_kbd_clk); end
        checks++; if (ps2_kbd_data !== 1'b1) begin errors++; $display("FAIL reset_data got %b want 1", ps2_kbd_data); end
        checks++; if (host.fifo_full !== 1'b0) begin errors++; $display("FAIL reset_full got %b want 0", host.fifo_full); end
        checks++; if (host.overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b want 0", host.overflow); end
        checks++; if (host.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", host.busy); end
    endtask

    task automatic test_single();
        bit ok;
        int s0, spans0, k;
        s0 = stop_seen;
        spans0 = lo_spans;
        drive_byte(8'h1C);
        exp_q.push_back(8'h1C);
        release_valid();
        wait_rx(1, 400, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL single_timeout got %0d frames want 1", rx_q.size()); end
        checks++; if (last_bits !== frame_of(8'h1C)) begin errors++; $display("FAIL single_bits got %h want %h", last_bits, frame_of(8'h1C)); end
        checks++; if (last_bits !== 11'h438) begin errors++; $display("FAIL single_seq got %h want 438", last_bits); end
        k = 0;
        while (stop_seen == s0 && k < 50) begin @(negedge clk_sys); k++; end
        checks++; if (lo_spans - spans0 !== 11) begin errors++; $display("FAIL single_spans got %0d want 11", lo_spans - spans0); end
        checks++; if (lo_err !== 0) begin errors++; $display("FAIL single_lowlen got %0d bad spans want 0", lo_err); end
        k = 0;
        while (host.busy !== 1'b0 && k < 200) begin @(negedge clk_sys); k++; end
        checks++; if (cyc - stop_rise_cyc !== GapTicks * ClkDiv) begin
            errors++; $display("FAIL single_busy_drop got %0d cycles want %0d", cyc - stop_rise_cyc, GapTicks * ClkDiv);
        end
        checks++; if ({ps2_kbd_clk, ps2_kbd_data} !== 2'b11) begin errors++; $display("FAIL single_idle got %b want 11", {ps2_kbd_clk, ps2_kbd_data}); end
        rx_q.delete(); par_q.delete(); exp_q.delete();
    endtask

    task automatic test_back_to_back();
        bit ok;
        drive_byte(8'hF0);
        drive_byte(8'h00);
        release_valid();
        exp_q.push_back(8'hF0);
        exp_q.push_back(8'h00);
        wait_rx(2, 600, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL b2b_timeout got %0d frames want 2", rx_q.size()); end
        for (int i = 0; i < 2 && i < rx_q.size(); i++) begin
            checks++; if (rx_q[i] !== exp_q[i]) begin errors++; $display("FAIL b2b_byte%0d got %h want %h", i, rx_q[i], exp_q[i]); end
            checks++; if (par_q[i] !== ~(^exp_q[i])) begin errors++; $display("FAIL b2b_par%0d got %b want %b", i, par_q[i], ~(^exp_q[i])); end
        end
        checks++; if (gap_last !== (GapTicks + 1) * ClkDiv) begin
            errors++; $display("FAIL b2b_gap got %0d cycles want %0d", gap_last, (GapTicks + 1) * ClkDiv);
        end
        wait_idle(200, ok);
        rx_q.delete(); par_q.delete(); exp_q.delete();
    endtask

    // One byte goes in flight, then 16 more fill the queue and a 17th is dropped.
    task automatic test_fill_overflow();
        bit ok;
        int f0, k;
        logic [7:0] b;
        f0 = fall_cnt;
        b = 8'($urandom_range(0, 255));
        drive_byte(b);
        exp_q.push_back(b);
        release_valid();
        k = 0;
        while (fall_cnt == f0 && k < 50) begin @(negedge clk_sys); k++; end
        for (int i = 0; i < Depth; i++) begin
            b = 8'($urandom_range(0, 255));
            drive_byte(b);
            exp_q.push_back(b);
        end
        release_valid();
        checks++; if (host.fifo_full !== 1'b1) begin errors++; $display("FAIL fill_full got %b want 1", host.fifo_full); end
        checks++; if (host.overflow !== 1'b0) begin errors++; $display("FAIL fill_noovf got %b want 0", host.overflow); end
        drive_byte(8'hA5);
        release_valid();
        checks++; if (host.overflow !== 1'b1) begin errors++; $display("FAIL fill_ovf got %b want 1", host.overflow); end
        checks++; if (host.fifo_full !== 1'b1) begin errors++; $display("FAIL fill_full2 got %b want 1", host.fifo_full); end
        wait_rx(Depth + 1, (Depth + 1) * 200, ok);
        wait_idle(400, ok);
        checks++; if (rx_q.size() !== exp_q.size()) begin errors++; $display("FAIL fill_count got %0d want %0d", rx_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
            checks++; if (rx_q[i] !== exp_q[i]) begin errors++; $display("FAIL fill_byte%0d got %h want %h", i, rx_q[i], exp_q[i]); end
        end
        checks++; if ({ps2_kbd_clk, ps2_kbd_data} !== 2'b11) begin errors++; $display("FAIL fill_idle got %b want 11", {ps2_kbd_clk, ps2_kbd_data}); end
        rx_q.delete(); par_q.delete(); exp_q.delete();
    endtask

    task automatic test_reset_midframe();
        int k, f0;
        for (int i = 0; i < 3; i++) drive_byte(8'($urandom_range(0, 255)));
        release_valid();
        k = 0;
        while (nbits != 6 && k < 400) begin @(negedge clk_sys); k++; end
        checks++; if (nbits !== 6) begin errors++; $display("FAIL rst_mid_reach got %0d bits want 6", nbits); end
        checks++; if (host.overflow !== 1'b1) begin errors++; $display("FAIL rst_mid_ovf_pre got %b want 1", host.overflow); end
        reset = 1'b1;
        @(negedge clk_sys);
        checks++; if ({ps2_kbd_clk, ps2_kbd_data} !== 2'b11) begin errors++; $display("FAIL rst_mid_lines got %b want 11", {ps2_kbd_clk, ps2_kbd_data}); end
        checks++; if (host.overflow !== 1'b0) begin errors++; $display("FAIL rst_mid_ovf got %b want 0", host.overflow); end
        checks++; if (host.busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy got %b want 0", host.busy); end
        reset = 1'b0;
        f0 = fall_cnt;
        repeat (200) @(negedge clk_sys);
        checks++; if (fall_cnt !== f0) begin errors++; $display("FAIL rst_mid_quiet got %0d edges want 0", fall_cnt - f0); end
        rx_q.delete(); par_q.delete(); exp_q.delete();
    endtask

    // With 15 queued, a write lands on the exact pop cycle: count stays 15, one more fills it.
    task automatic test_same_cycle_pop();
        bit ok;
        int f0, s0, k;
        logic [7:0] b;
        f0 = fall_cnt;
        b = 8'($urandom_range(0, 255));
        drive_byte(b);
        exp_q.push_back(b);
        release_valid();
        k = 0;
        while (fall_cnt == f0 && k < 50) begin @(negedge clk_sys); k++; end
        s0 = stop_seen;
        for (int i = 0; i < Depth - 1; i++) begin
            b = 8'($urandom_range(0, 255));
            drive_byte(b);
            exp_q.push_back(b);
        end
        release_valid();
        k = 0;
        while (stop_seen == s0 && k < 200) begin @(negedge clk_sys); k++; end
        repeat (18) @(negedge clk_sys);
        b = 8'($urandom_range(0, 255));
        drive_byte(b);
        exp_q.push_back(b);
        release_valid();
        checks++; if (start_cyc - stop_rise_cyc !== (GapTicks + 1) * ClkDiv) begin
            errors++; $display("FAIL pop_align got %0d cycles want %0d", start_cyc - stop_rise_cyc, (GapTicks + 1) * ClkDiv);
        end
        checks++; if (host.fifo_full !== 1'b0) begin errors++; $display("FAIL pop_full got %b want 0", host.fifo_full); end
        checks++; if (host.overflow !== 1'b0) begin errors++; $display("FAIL pop_ovf got %b want 0", host.overflow); end
        b = 8'($urandom_range(0, 255));
        drive_byte(b);
        exp_q.push_back(b);
        release_valid();
        checks++; if (host.fifo_full !== 1'b1) begin errors++; $display("FAIL pop_full_after got %b want 1", host.fifo_full); end
        wait_rx(exp_q.size(), exp_q.size() * 200, ok);
        wait_idle(400, ok);
        checks++; if (rx_q.size() !== exp_q.size()) begin errors++; $display("FAIL pop_count got %0d want %0d", rx_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
            checks++; if (rx_q[i] !== exp_q[i]) begin errors++; $display("FAIL pop_byte%0d got %h want %h", i, rx_q[i], exp_q[i]); end
        end
        checks++; if (host.overflow !== 1'b0) begin errors++; $display("FAIL pop_ovf_end got %b want 0", host.overflow); end
        rx_q.delete(); par_q.delete(); exp_q.delete();
    endtask

    // Writes are paced so fewer than Depth bytes are ever outstanding, so none may drop.
    task automatic test_random_stream();
        bit ok;
        int sent = 0, k = 0;
        logic [7:0] b;
        while (sent < 200 && k < 60000) begin
            if ((sent - rx_q.size()) < Depth && $urandom_range(0, 3) != 0) begin
                b = 8'($urandom_range(0, 255));
                drive_byte(b);
                exp_q.push_back(b);
                sent++;
            end else begin
                release_valid();
            end
            k++;
        end
        release_valid();
        wait_rx(200, 30000, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL rand_timeout got %0d frames want 200", rx_q.size()); end
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
            checks++; if (rx_q[i] !== exp_q[i]) begin errors++; $display("FAIL rand_byte%0d got %h want %h", i, rx_q[i], exp_q[i]); end
        end
        checks++; if (frame_err !== 0) begin errors++; $display("FAIL rand_frame got %0d bad frames want 0", frame_err); end
        checks++; if (dtrans_err !== 0) begin errors++; $display("FAIL rand_dlow got %0d transitions want 0", dtrans_err); end
        checks++; if (lo_err !== 0) begin errors++; $display("FAIL rand_lowlen got %0d bad spans want 0", lo_err); end
        checks++; if (host.overflow !== 1'b0) begin errors++; $display("FAIL rand_ovf got %b want 0", host.overflow); end
    endtask

    initial begin
        host.data_in    = 8'h00;
        host.data_valid = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_fill_overflow();
        test_reset_midframe();
        test_same_cycle_pop();
        test_random_stream();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog expired at cycle %0d want finish earlier", cyc);
        $fatal(1, "watchdog");
    end
endmodule
